clahe_hist_accumulator: RTL

- Histogram statistics stage directly upstream of clahe_true_dual_port_ram; it drives both RAM ports.
- Each accepted pixel is counted into bin {tile, pixel} by read-modify-write: read on port A, write back on port B one cycle later.
- Distance-1 read/write hazards are resolved by forwarding.
- Also zeroes the whole histogram RAM on request, two words per cycle over both ports.

---
 rtl/clahe_hist_pkg.sv | 15 +
 rtl/clahe_hist_rmw_pipe.sv | 63 ++++++
 rtl/clahe_hist_accumulator.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/clahe_hist_pkg.sv
// Shared definitions for the CLAHE histogram stage: FSM encoding and default
// widths reused by the histogram RAM instance and the CDF stage.
package clahe_hist_pkg;

    localparam int unsigned DEF_TILE_BITS  = 6;
    localparam int unsigned DEF_BIN_BITS   = 8;
    localparam int unsigned DEF_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } hist_state_t;

endpackage

// File: rtl/clahe_hist_rmw_pipe.sv
// Two-stage read-modify-write pipe: S0 address capture, S1 forwarding mux,
// saturating increment and write-back request.
module clahe_hist_rmw_pipe
    import clahe_hist_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_TILE_BITS + DEF_BIN_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_fire,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_sat
);

    logic                  r_s1_valid;
    logic [ADDR_WIDTH-1:0] r_s1_addr;
    logic                  r_prev_valid;
    logic [ADDR_WIDTH-1:0] r_prev_addr;
    logic [DATA_WIDTH-1:0] r_prev_data;

    logic                  w_fwd;
    logic [DATA_WIDTH-1:0] w_base;
    logic                  w_full;
    logic [DATA_WIDTH-1:0] w_cnt;

    // The RAM read issued this cycle races the write of the previous pixel,
    // so a back-to-back hit on the same bin must take the in-flight count.
    assign w_fwd  = r_prev_valid && (r_prev_addr == r_s1_addr);
    assign w_base = w_fwd ? r_prev_data : i_rd_data;
    assign w_full = &w_base;
    assign w_cnt  = w_full ? w_base : w_base + DATA_WIDTH'(1);

    assign o_wr_en   = r_s1_valid;
    assign o_wr_addr = r_s1_addr;
    assign o_wr_data = w_cnt;
    assign o_sat     = r_s1_valid && w_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_addr    <= '0;
            r_prev_valid <= 1'b0;
            r_prev_addr  <= '0;
            r_prev_data  <= '0;
        end else begin
            r_s1_valid   <= i_fire;
            if (i_fire) begin
                r_s1_addr <= i_addr;
            end
            r_prev_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_prev_addr <= r_s1_addr;
                r_prev_data <= w_cnt;
            end
        end
    end

endmodule

// File: rtl/clahe_hist_accumulator.sv
// Per-tile histogram accumulator driving both ports of the histogram RAM.
// Define CLAHE_HIST_RST_CLEAR_EN to sweep the RAM to zero out of reset.
module clahe_hist_accumulator
    import clahe_hist_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned TILE_BITS  = DEF_TILE_BITS,
    parameter int unsigned BIN_BITS   = DEF_BIN_BITS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [BIN_BITS-1:0]             in_pixel,
    input  logic [TILE_BITS-1:0]            in_tile,
    input  logic                            clear_req,
    output logic                            clear_done,
    output logic                            busy,
    output logic                            sat_flag,
    output logic                            ram_ena,
    output logic                            ram_wea,
    output logic [TILE_BITS+BIN_BITS-1:0]   ram_addra,
    output logic [DATA_WIDTH-1:0]           ram_dina,
    input  logic [DATA_WIDTH-1:0]           ram_douta,
    output logic                            ram_enb,
    output logic                            ram_web,
    output logic [TILE_BITS+BIN_BITS-1:0]   ram_addrb,
    output logic [DATA_WIDTH-1:0]           ram_dinb
);

    localparam int unsigned ADDR_WIDTH = TILE_BITS + BIN_BITS;
    localparam int unsigned DEPTH      = 32'(1) << ADDR_WIDTH;
    localparam int unsigned K_WIDTH    = ADDR_WIDTH - 1;
    localparam logic [K_WIDTH-1:0] LAST_K = K_WIDTH'(DEPTH / 2 - 1);

    hist_state_t         r_state;
    hist_state_t         w_state_nxt;
    logic [K_WIDTH-1:0]  r_k;
    logic [K_WIDTH-1:0]  w_k_nxt;
    logic                r_clear_done;
    logic                w_clear_done_nxt;
    logic                r_sat;
    logic                w_sat_nxt;

    logic                  w_fire;
    logic [ADDR_WIDTH-1:0] w_pix_addr;
    logic                  w_wr_en;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic                  w_sat_hit;

    assign in_ready   = (r_state == ST_IDLE) && !rst;
    assign busy       = (r_state != ST_IDLE);
    assign clear_done = r_clear_done;
    assign sat_flag   = r_sat;
    assign w_fire     = in_valid && in_ready;
    assign w_pix_addr = {in_tile, in_pixel};

    clahe_hist_rmw_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rmw_pipe (
        .clk       (clk),
        .rst       (rst),
        .i_fire    (w_fire),
        .i_addr    (w_pix_addr),
        .i_rd_data (ram_douta),
        .o_wr_en   (w_wr_en),
        .o_wr_addr (w_wr_addr),
        .o_wr_data (w_wr_data),
        .o_sat     (w_sat_hit)
    );

    // State register and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef CLAHE_HIST_RST_CLEAR_EN
            r_state <= ST_CLEAR;
`else
            r_state <= ST_IDLE;
`endif
            r_k          <= '0;
            r_clear_done <= 1'b0;
            r_sat        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_k          <= w_k_nxt;
            r_clear_done <= w_clear_done_nxt;
            r_sat        <= w_sat_nxt;
        end
    end

    // Next-state logic and RAM port steering: pixel RMW by default, the
    // zeroing sweep owns both ports while in CLEAR.
    always_comb begin
        w_state_nxt      = r_state;
        w_k_nxt          = r_k;
        w_clear_done_nxt = 1'b0;
        w_sat_nxt        = r_sat || w_sat_hit;

        ram_ena   = w_fire;
        ram_wea   = 1'b0;
        ram_addra = w_pix_addr;
        ram_dina  = '0;
        ram_enb   = w_wr_en;
        ram_web   = w_wr_en;
        ram_addrb = w_wr_addr;
        ram_dinb  = w_wr_data;

        case (r_state)
            ST_IDLE: begin
                if (clear_req) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_CLEAR;
                w_k_nxt     = '0;
            end
            ST_CLEAR: begin
                if (!rst) begin
                    ram_ena   = 1'b1;
                    ram_wea   = 1'b1;
                    ram_addra = {r_k, 1'b0};
                    ram_enb   = 1'b1;
                    ram_web   = 1'b1;
                    ram_addrb = {r_k, 1'b1};
                    ram_dinb  = '0;
                end
                if (r_k == LAST_K) begin
                    w_state_nxt      = ST_IDLE;
                    w_k_nxt          = '0;
                    w_clear_done_nxt = 1'b1;
                    w_sat_nxt        = 1'b0;
                end else begin
                    w_k_nxt = r_k + K_WIDTH'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
